// File: rtl/serial_addbit_engine.sv
// serial_addbit_engine
//   Bit-serial WIDTH-bit adder. One full-adder cell is reused every clock.
//   The carry is registered and fed back as the next carry-in. Operands
//   shift through the cell LSB-first, and the sum bits shift in from the MSB.
//
//   Ports
//     clk    - rising-edge clock
//     rst_n  - asynchronous active-low reset
//     start  - request, sampled only in IDLE or DONE
//     a, b   - operands, captured on an accepted start
//     ci     - carry-in, captured on an accepted start
//     busy   - high while the bit-steps are running
//     done   - one-cycle pulse when sum/co take a new result
//     sum    - registered parallel result, held between operations
//     co     - registered final carry-out, held between operations
module serial_addbit_engine #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, nxt;
  logic [WIDTH-1:0] a_sr, b_sr, s_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             accept, last;
  logic             bit_s, bit_c;
  logic [WIDTH:0]   s_cat;
  logic [WIDTH-1:0] s_nxt;

  // A new operation is accepted from IDLE, and also from DONE so that
  // operations can run back-to-back.
  assign accept = start && (state == IDLE || state == DONE);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // Full-adder cell, same truth table as the gate-level 1-bit adder.
  assign bit_s = a_sr[0] ^ b_sr[0] ^ carry;
  assign bit_c = (a_sr[0] & b_sr[0]) | ((a_sr[0] ^ b_sr[0]) & carry);

  // The new sum bit enters at the MSB. Concatenating before the shift keeps
  // this valid for WIDTH=1, where s_sr has no upper bits to slice.
  assign s_cat = {bit_s, s_sr};
  assign s_nxt = s_cat[WIDTH:1];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (start) nxt = RUN;
      RUN:     if (last)  nxt = DONE;
      DONE:    nxt = start ? RUN : IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand capture, one bit-step per RUN cycle, result latch.
  // A start in RUN is ignored because accept is false there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      co    <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      b_sr  <= b;
      s_sr  <= '0;
      carry <= ci;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr  <= a_sr >> 1;
      b_sr  <= b_sr >> 1;
      s_sr  <= s_nxt;
      carry <= bit_c;
      cnt   <= cnt + CW'(1);
      if (last) begin
        sum <= s_nxt;
        co  <= bit_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_addbit_engine.sv
module tb_serial_addbit_engine;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0, ci = 1'b0;
  logic [7:0]  a = '0, b = '0;
  logic        busy, done, co;
  logic [7:0]  sum;

  logic        start1 = 1'b0, ci1 = 1'b0, busy1, done1, co1;
  logic [0:0]  a1 = '0, b1 = '0, sum1;
  logic        start32 = 1'b0, ci32 = 1'b0, busy32, done32, co32;
  logic [31:0] a32 = '0, b32 = '0, sum32;

  int checks = 0, failures = 0;
  logic [7:0] prev_sum = '0;
  logic       prev_co = 1'b0;

  always #5 clk = ~clk;

  serial_addbit_engine #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .ci(ci),
    .busy(busy), .done(done), .sum(sum), .co(co));

  serial_addbit_engine #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .ci(ci1),
    .busy(busy1), .done(done1), .sum(sum1), .co(co1));

  serial_addbit_engine #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32), .ci(ci32),
    .busy(busy32), .done(done32), .sum(sum32), .co(co32));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One operation on the WIDTH=8 instance. Leaves the bench #1 after the
  // edge that raised done, so the caller can start again in DONE.
  // mid=1 pulses start with different operands during RUN.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb_v,
                       input logic tci, input bit mid);
    int n, bsy;
    logic [8:0] exp;
    exp = {1'b0, ta} + {1'b0, tb_v} + {8'd0, tci};
    a = ta; b = tb_v; ci = tci; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); ci = 1'($urandom);
    n = 1; bsy = 0;
    while (!done && n < 40) begin
      if (busy) bsy++;
      if (n == 4) begin
        chk("hold_sum", {56'd0, sum}, {56'd0, prev_sum});
        chk("hold_co", {63'd0, co}, {63'd0, prev_co});
      end
      if (mid) begin
        if (n >= 3 && n <= 5) begin start = 1'b1; a = 8'hFF; b = 8'hFF; end
        else start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    chk("latency", 64'(n), 64'd9);
    chk("busy_cycles", 64'(bsy), 64'd8);
    chk("sum", {56'd0, sum}, {56'd0, exp[7:0]});
    chk("co", {63'd0, co}, {63'd0, exp[8]});
    prev_sum = exp[7:0];
    prev_co  = exp[8];
  endtask

  initial begin
    int n;
    bit saw;
    #2;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_sum", {56'd0, sum}, 64'd0);
    chk("rst_co", {63'd0, co}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);   // 00, co=1
    @(posedge clk); #1;
    chk("done_one_cycle", {63'd0, done}, 64'd0);
    do_op(8'hA5, 8'h5A, 1'b1, 1'b0);   // 00, co=1
    @(posedge clk); #1;
    do_op(8'h03, 8'h04, 1'b1, 1'b0);   // 08, co=0
    @(posedge clk); #1;
    chk("idle_hold_sum", {56'd0, sum}, 64'h08);
    chk("idle_hold_co", {63'd0, co}, 64'd0);

    // start held high: one result every 9 cycles
    a = 8'h10; b = 8'h20; ci = 1'b0; start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      do begin @(posedge clk); #1; n++; end while (!done && n < 40);
      chk("held_period", 64'(n), 64'd9);
      chk("held_sum", {56'd0, sum}, 64'h30);
    end
    start = 1'b0;
    @(posedge clk); #1;
    prev_sum = 8'h30; prev_co = 1'b0;

    // start pulses during RUN must not disturb the operation
    do_op(8'h10, 8'h20, 1'b0, 1'b1);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of RUN
    a = 8'hFF; b = 8'hFF; ci = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("pre_abort_busy", {63'd0, busy}, 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_done", {63'd0, done}, 64'd0);
    chk("abort_sum", {56'd0, sum}, 64'd0);
    chk("abort_co", {63'd0, co}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (12) begin @(posedge clk); #1; saw |= done; end
    chk("abort_no_done", {63'd0, saw}, 64'd0);
    prev_sum = '0; prev_co = 1'b0;
    do_op(8'hFF, 8'hFF, 1'b0, 1'b0);   // FE, co=1
    @(posedge clk); #1;

    // Random regression with start gaps of 0..3 cycles
    for (int i = 0; i < 1000; i++) begin
      do_op(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    // WIDTH=1
    a1 = 1'b1; b1 = 1'b1; ci1 = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    chk("w1_busy", {63'd0, busy1}, 64'd1);
    chk("w1_no_done_yet", {63'd0, done1}, 64'd0);
    @(posedge clk); #1;
    chk("w1_done", {63'd0, done1}, 64'd1);
    chk("w1_sum", {63'd0, sum1}, 64'd1);
    chk("w1_co", {63'd0, co1}, 64'd1);

    // WIDTH=32
    a32 = 32'hFFFF_FFFF; b32 = '0; ci32 = 1'b1; start32 = 1'b1;
    @(posedge clk); #1;
    start32 = 1'b0;
    n = 1;
    while (!done32 && n < 80) begin @(posedge clk); #1; n++; end
    chk("w32_latency", 64'(n), 64'd33);
    chk("w32_sum", {32'd0, sum32}, 64'd0);
    chk("w32_co", {63'd0, co32}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
